// File: rtl/ship_lane_tracker.sv
// Ship-position engine: NSHIP ships on an NPOS-slot lane with edge/repeat moves,
// optional wrap-around, registered collision flags and a saturating hit counter.
module ship_lane_tracker #(
   parameter int unsigned NSHIP  = 2,
   parameter int unsigned NPOS   = 8,
   parameter int unsigned REPEAT = 4,
   parameter int unsigned WRAP   = 0,
   parameter int unsigned HW     = 8,
   localparam int unsigned PW    = $clog2(NPOS),
   localparam int unsigned RW    = $clog2(REPEAT + 1)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NSHIP-1:0]        LEFT,
   input  logic [NSHIP-1:0]        RIGHT,
   output logic [NSHIP*PW-1:0]     POS,
   output logic [NSHIP*NPOS-1:0]   ONEHOT,
   output logic [NSHIP-1:0]        COLL,
   output logic                    MP,
   output logic [HW-1:0]           HITS
);

   // REPEAT=0 gives a zero-width counter; keep one dummy bit instead.
   localparam int unsigned    RCW     = (RW < 1) ? 1 : RW;
   localparam logic [PW-1:0]  LAST    = PW'(NPOS - 1);
   localparam logic [RCW-1:0] RC_LAST = RCW'((REPEAT == 0) ? 0 : REPEAT - 1);

   logic [PW-1:0]    pos_q [NSHIP];
   logic [PW-1:0]    pos_d [NSHIP];
   logic [RCW-1:0]   rc_q  [NSHIP];
   logic [RCW-1:0]   rc_d  [NSHIP];
   logic [NSHIP-1:0] l_q;
   logic [NSHIP-1:0] r_q;
   logic [NSHIP-1:0] press;
   logic [NSHIP-1:0] move;
   logic [NSHIP-1:0] coll_c;
   logic [NSHIP-1:0] coll_q;
   logic             any_coll;
   logic             mp_q;
   logic [HW-1:0]    hits_q;

   function automatic logic [PW-1:0] init_pos(input int unsigned i);
      int unsigned v;
      v = (i * NPOS) / NSHIP;
      return v[PW-1:0];
   endfunction

   function automatic logic [PW-1:0] step_left(input logic [PW-1:0] p);
      logic [PW-1:0] n;
      if (p == '0) n = (WRAP != 0) ? LAST : '0;
      else         n = p - PW'(1);
      return n;
   endfunction

   function automatic logic [PW-1:0] step_right(input logic [PW-1:0] p);
      logic [PW-1:0] n;
      if (p == LAST) n = (WRAP != 0) ? '0 : LAST;
      else           n = p + PW'(1);
      return n;
   endfunction

   // Move decision: a fresh press moves at once, a held single button repeats.
   always_comb begin
      for (int i = 0; i < NSHIP; i++) begin
         pos_d[i] = pos_q[i];
         rc_d[i]  = '0;
         press[i] = RIGHT[i] ? ~r_q[i] : ~l_q[i];
         move[i]  = 1'b0;
         if (LEFT[i] ^ RIGHT[i]) begin
            if (press[i]) begin
               move[i] = 1'b1;
            end else if (REPEAT != 0) begin
               if (rc_q[i] == RC_LAST) move[i] = 1'b1;
               else                    rc_d[i] = rc_q[i] + RCW'(1);
            end
         end
         if (move[i]) pos_d[i] = RIGHT[i] ? step_right(pos_q[i]) : step_left(pos_q[i]);
      end
   end

   always_comb begin
      coll_c = '0;
      for (int i = 0; i < NSHIP; i++) begin
         for (int j = 0; j < NSHIP; j++) begin
            if (i != j && pos_q[i] == pos_q[j]) coll_c[i] = 1'b1;
         end
      end
   end

   assign any_coll = |coll_c;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NSHIP; i++) begin
            pos_q[i] <= init_pos(i);
            rc_q[i]  <= '0;
         end
         // Capture held buttons so they do not count as presses after reset.
         l_q    <= LEFT;
         r_q    <= RIGHT;
         coll_q <= '0;
         mp_q   <= 1'b0;
         hits_q <= '0;
      end else begin
         for (int i = 0; i < NSHIP; i++) begin
            pos_q[i] <= pos_d[i];
            rc_q[i]  <= rc_d[i];
         end
         l_q    <= LEFT;
         r_q    <= RIGHT;
         coll_q <= coll_c;
         mp_q   <= any_coll;
         if (!mp_q && any_coll && hits_q != '1) hits_q <= hits_q + HW'(1);
      end
   end

   always_comb begin
      POS    = '0;
      ONEHOT = '0;
      for (int i = 0; i < NSHIP; i++) begin
         POS[i*PW +: PW]      = pos_q[i];
         ONEHOT[i*NPOS +: NPOS] = NPOS'(1) << pos_q[i];
      end
   end

   assign COLL = coll_q;
   assign MP   = mp_q;
   assign HITS = hits_q;

endmodule
